game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning cycles per move tick (legal range 2..255).
REQ-002 SHALL have port clka, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port restart, input, 1, meaning synchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports btn_left, btn_right, btn_rotate, input, 1 each, meaning level player buttons, synchronous to clka.
REQ-005 SHALL have port touched, input, 1, meaning the datapath reports the active piece has landed.
REQ-006 SHALL have port error_in, input, 1, meaning the datapath reports a redraw overflow.
REQ-007 SHALL have port board_in, input, 32, meaning the board produced by the datapath.
REQ-008 SHALL have ports location_in, input, 5, and rotation_in, input, 2, meaning the piece position produced by the datapath.
REQ-009 SHALL have ports state and old_state, output, 3 each, meaning the current and previous-cycle game state.
REQ-010 SHALL have port move, output, 2, meaning the move code: 0 none, 1 left, 2 right, 3 rotate.
REQ-011 SHALL have port board_out, output, 32, meaning the registered board fed back to the datapath.
REQ-012 SHALL have ports location_out, output, 5, and rotation_out, output, 2, meaning the registered piece position.
REQ-013 SHALL have ports game_over, output, 1, and piece_count, output, 8, meaning GAMEOVER status and pieces spawned.

Function
REQ-014 SHALL encode states GEN=0, MOVE=1, LAND=2, CLEAR=3, NEWBOARD=4, GAMEOVER=5; codes 6 and 7 SHALL transition to GEN.
REQ-015 SHALL transition GEN->MOVE after 1 cycle; in MOVE, touched=1 SHALL transition to LAND, otherwise the FSM stays in MOVE.
REQ-016 SHALL transition LAND->CLEAR after 1 cycle, CLEAR->GAMEOVER if error_in=1, else CLEAR->NEWBOARD, and NEWBOARD->GEN after 1 cycle.
REQ-017 SHALL hold GAMEOVER until reset or a rising edge on btn_rotate; that edge SHALL transition to NEWBOARD and clear board_out to 0 on the same edge.
REQ-018 SHALL register old_state as state delayed by exactly one cycle.
REQ-019 SHALL detect button rising edges with a one-cycle registered previous value; a level held high SHALL produce one edge only.
REQ-020 SHALL hold one pending move: a new edge overwrites it; simultaneous edges SHALL be resolved by priority rotate > left > right.
REQ-021 SHALL run the tick counter only in MOVE, reset it to 0 on MOVE entry, and wrap it from TICK_DIV-1 to 0.
REQ-022 SHALL drive the pending move on move for exactly the cycle where state=MOVE and the counter equals TICK_DIV-1, then clear the pending move; move SHALL be 0 in all other cycles.
REQ-023 SHALL discard an edge that arrives in the same cycle a pending move is issued only if it is the same code; a different code SHALL become the new pending move.
REQ-024 SHALL clear the pending move on any exit from MOVE.
REQ-025 SHALL load board_out from board_in at the end of every MOVE and CLEAR cycle, and SHALL otherwise hold it.
REQ-026 SHALL load location_out and rotation_out from location_in and rotation_in during MOVE, and SHALL load 0 in NEWBOARD.
REQ-027 SHALL increment piece_count on each GEN cycle, saturating at 255.
REQ-028 SHALL drive game_over=1 if and only if state=GAMEOVER (registered).
REQ-029 SHALL give touched priority over a tick in the same MOVE cycle: the move is still issued that cycle and the state goes to LAND.

Reset
REQ-030 SHALL, when restart=0 at a clka edge, set state=NEWBOARD, old_state=NEWBOARD, move=0, board_out=0, location_out=0, rotation_out=0, piece_count=0, game_over=0, tick counter=0, pending move=0, and button history=0.
REQ-031 SHALL give reset priority over every event, including mid-MOVE and during GAMEOVER.

Structure
REQ-032 SHALL take the state encodings and move codes from a shared package (tetris_pkg) that is also used by the datapath.
REQ-033 SHALL place the edge detection and pending-move arbitration in one sub-module, btn_sync.

Verification
REQ-034 SHALL verify reset then release: state sequence NEWBOARD, GEN, MOVE, MOVE...; piece_count=1.
REQ-035 SHALL verify btn_left pulsed in MOVE with TICK_DIV=4: move=1 for exactly one cycle, at counter=3; move=0 otherwise.
REQ-036 SHALL verify btn_left and btn_rotate rising in the same cycle: the single issued move=3.
REQ-037 SHALL verify touched=1 in MOVE with error_in=0: sequence LAND, CLEAR, NEWBOARD, GEN; board_out equals board_in captured in CLEAR.
REQ-038 SHALL verify error_in=1 in CLEAR: GAMEOVER, game_over=1; a btn_rotate edge then gives NEWBOARD with board_out=0.
REQ-039 SHALL verify restart=0 asserted mid-MOVE with a move pending: all outputs take their reset values next cycle and no move is issued afterwards.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game state and move encodings for controller and datapath
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_GEN      = 3'd0,
        ST_MOVE     = 3'd1,
        ST_LAND     = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_NEWBOARD = 3'd4,
        ST_GAMEOVER = 3'd5
    } game_state_t;

    typedef enum logic [1:0] {
        MV_NONE   = 2'd0,
        MV_LEFT   = 2'd1,
        MV_RIGHT  = 2'd2,
        MV_ROTATE = 2'd3
    } move_t;

    // Simultaneous button edges resolve rotate > left > right.
    function automatic move_t move_from_edges(input logic rot, input logic left, input logic right);
        if (rot)
            return MV_ROTATE;
        else if (left)
            return MV_LEFT;
        else if (right)
            return MV_RIGHT;
        else
            return MV_NONE;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - controller <-> datapath exchange bundle
interface game_ctrl_if;
    logic        touched;
    logic        error_in;
    logic [31:0] board_in;
    logic [4:0]  location_in;
    logic [1:0]  rotation_in;
    logic [1:0]  move;
    logic [31:0] board_out;
    logic [4:0]  location_out;
    logic [1:0]  rotation_out;

    modport master (
        input  touched, error_in, board_in, location_in, rotation_in,
        output move, board_out, location_out, rotation_out
    );

    modport slave (
        output touched, error_in, board_in, location_in, rotation_in,
        input  move, board_out, location_out, rotation_out
    );
endinterface

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - button edge detection and single pending-move arbitration
module btn_sync
    import tetris_pkg::*;
(
    input  logic  clka,
    input  logic  restart,
    input  logic  btn_left,
    input  logic  btn_right,
    input  logic  btn_rotate,
    input  logic  enable,
    input  logic  issue,
    input  logic  flush,
    output move_t pending,
    output logic  rotate_rise
);

    logic [2:0] prev_q;
    logic       rise_left;
    logic       rise_right;
    move_t      code;

    assign rise_left   = btn_left   & ~prev_q[0];
    assign rise_right  = btn_right  & ~prev_q[1];
    assign rotate_rise = btn_rotate & ~prev_q[2];
    assign code        = move_from_edges(rotate_rise, rise_left, rise_right);

    // Button history and pending move; edges only count while the piece is moving.
    always_ff @(posedge clka) begin
        if (!restart) begin
            prev_q  <= 3'b000;
            pending <= MV_NONE;
        end else begin
            prev_q <= {btn_rotate, btn_right, btn_left};
            if (flush)
                pending <= MV_NONE;
            else if (issue)
                pending <= (code != MV_NONE && code != pending) ? code : MV_NONE;
            else if (enable && code != MV_NONE)
                pending <= code;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game state machine, move ticking and board/piece registers
module game_ctrl
    import tetris_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    game_ctrl_if.master dp,
    output logic [2:0]  state,
    output logic [2:0]  old_state,
    output logic        game_over,
    output logic [7:0]  piece_count
);

    game_state_t cur_q;
    game_state_t old_q;
    logic [7:0]  tick_q;
    logic        tick_hit;
    logic        in_move;
    logic        issue;
    logic        leave_move;
    logic        rotate_rise;
    move_t       pending;

    assign in_move    = (cur_q == ST_MOVE);
    assign tick_hit   = (tick_q == 8'(TICK_DIV - 1));
    assign issue      = in_move && tick_hit;
    assign leave_move = in_move && dp.touched;

    assign dp.move   = issue ? pending : MV_NONE;
    assign state     = cur_q;
    assign old_state = old_q;

    btn_sync u_btn_sync (
        .clka        (clka),
        .restart     (restart),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_rotate  (btn_rotate),
        .enable      (in_move),
        .issue       (issue),
        .flush       (leave_move),
        .pending     (pending),
        .rotate_rise (rotate_rise)
    );

    // Game FSM with its registered outputs; the tick counter idles at 0 outside MOVE.
    always_ff @(posedge clka) begin
        if (!restart) begin
            cur_q           <= ST_NEWBOARD;
            old_q           <= ST_NEWBOARD;
            tick_q          <= 8'd0;
            game_over       <= 1'b0;
            piece_count     <= 8'd0;
            dp.board_out    <= 32'd0;
            dp.location_out <= 5'd0;
            dp.rotation_out <= 2'd0;
        end else begin
            old_q     <= cur_q;
            tick_q    <= 8'd0;
            game_over <= 1'b0;
            case (cur_q)
                ST_GEN: begin
                    cur_q <= ST_MOVE;
                    if (piece_count != 8'hFF)
                        piece_count <= piece_count + 8'd1;
                end
                ST_MOVE: begin
                    dp.board_out    <= dp.board_in;
                    dp.location_out <= dp.location_in;
                    dp.rotation_out <= dp.rotation_in;
                    tick_q          <= tick_hit ? 8'd0 : tick_q + 8'd1;
                    if (dp.touched)
                        cur_q <= ST_LAND;
                end
                ST_LAND: begin
                    cur_q <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    dp.board_out <= dp.board_in;
                    if (dp.error_in) begin
                        cur_q     <= ST_GAMEOVER;
                        game_over <= 1'b1;
                    end else begin
                        cur_q <= ST_NEWBOARD;
                    end
                end
                ST_NEWBOARD: begin
                    dp.location_out <= 5'd0;
                    dp.rotation_out <= 2'd0;
                    cur_q           <= ST_GEN;
                end
                ST_GAMEOVER: begin
                    if (rotate_rise) begin
                        cur_q        <= ST_NEWBOARD;
                        dp.board_out <= 32'd0;
                    end else begin
                        game_over <= 1'b1;
                    end
                end
                default: begin
                    cur_q <= ST_GEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl
module tb_game_ctrl;

    localparam int TD = 4;

    typedef struct {
        logic [1:0] code;
        int         at;
    } exp_t;

    logic       clka = 1'b0;
    logic       restart;
    logic       btn_left, btn_right, btn_rotate;
    logic [2:0] state, old_state;
    logic       game_over;
    logic [7:0] piece_count;

    int   checks = 0;
    int   errors = 0;
    int   nc = 0;
    int   m0 = 0;
    exp_t sb[$];

    game_ctrl_if dp ();

    game_ctrl #(.TICK_DIV(TD)) dut (
        .clka        (clka),
        .restart     (restart),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_rotate  (btn_rotate),
        .dp          (dp.master),
        .state       (state),
        .old_state   (old_state),
        .game_over   (game_over),
        .piece_count (piece_count)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; sample at the falling edge and settle the scoreboard for move.
    task automatic cycle();
        exp_t e;
        @(negedge clka);
        nc++;
        if (dp.move != 2'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_move", 32'(dp.move), 32'd0);
            end else begin
                e = sb.pop_front();
                check("move_code", 32'(dp.move), 32'(e.code));
                check("move_cycle", 32'(nc), 32'(e.at));
            end
        end else if (sb.size() != 0 && sb[0].at <= nc) begin
            e = sb.pop_front();
            check("move_missing", 32'(dp.move), 32'(e.code));
        end
    endtask

    task automatic wait_tick(input int t);
        while (((nc - m0) % TD) != t)
            cycle();
    endtask

    // Drive button levels for the current cycle; predict when the move is issued.
    task automatic press(input logic l, input logic r, input logic o,
                         input logic [1:0] code, input bit expect_issue);
        int t;
        t = (nc - m0) % TD;
        btn_left   = l;
        btn_right  = r;
        btn_rotate = o;
        if (expect_issue)
            sb.push_back('{code, (t <= TD - 2) ? nc + (TD - 1 - t) : nc + TD});
    endtask

    task automatic release_btns();
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_rotate = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_state", 32'(state), 32'd4);
        check("rst_old_state", 32'(old_state), 32'd4);
        check("rst_move", 32'(dp.move), 32'd0);
        check("rst_board", dp.board_out, 32'd0);
        check("rst_loc", 32'(dp.location_out), 32'd0);
        check("rst_rot", 32'(dp.rotation_out), 32'd0);
        check("rst_pieces", 32'(piece_count), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
    endtask

    initial begin
        restart        = 1'b0;
        release_btns();
        dp.touched     = 1'b0;
        dp.error_in    = 1'b0;
        dp.board_in    = 32'd0;
        dp.location_in = 5'd0;
        dp.rotation_in = 2'd0;

        cycle();
        cycle();
        check_reset_vals();

        // Release: NEWBOARD -> GEN -> MOVE
        restart = 1'b1;
        cycle();
        check("rel_gen", 32'(state), 32'd0);
        check("rel_old_newboard", 32'(old_state), 32'd4);
        cycle();
        m0 = nc;
        check("rel_move", 32'(state), 32'd1);
        check("rel_old_gen", 32'(old_state), 32'd0);
        check("rel_pieces", 32'(piece_count), 32'd1);
        cycle();
        check("rel_move_stay", 32'(state), 32'd1);

        // Single left pulse
        wait_tick(1);
        press(1, 0, 0, 2'd1, 1);
        cycle();
        release_btns();
        repeat (6) cycle();

        // Right held high yields one move only
        wait_tick(0);
        press(0, 1, 0, 2'd2, 1);
        repeat (10) cycle();
        release_btns();

        // Left and rotate together resolve to rotate
        wait_tick(0);
        press(1, 0, 1, 2'd3, 1);
        cycle();
        release_btns();
        repeat (5) cycle();

        // Same code in the issue cycle is discarded
        wait_tick(1);
        press(1, 0, 0, 2'd1, 1);
        cycle();
        release_btns();
        cycle();
        press(1, 0, 0, 2'd1, 0);
        cycle();
        release_btns();
        repeat (6) cycle();

        // Different code in the issue cycle becomes the next pending move
        wait_tick(1);
        press(0, 0, 1, 2'd3, 1);
        cycle();
        release_btns();
        cycle();
        press(0, 1, 0, 2'd2, 1);
        cycle();
        release_btns();
        repeat (6) cycle();

        // Touch on a tick: move still issued, then LAND/CLEAR/NEWBOARD/GEN
        wait_tick(1);
        press(1, 0, 0, 2'd1, 1);
        cycle();
        release_btns();
        cycle();
        dp.touched     = 1'b1;
        dp.board_in    = 32'hA5A5_0001;
        dp.location_in = 5'd17;
        dp.rotation_in = 2'd2;
        cycle();
        dp.touched  = 1'b0;
        dp.board_in = 32'h1234_5678;
        check("touch_land", 32'(state), 32'd2);
        check("land_board", dp.board_out, 32'hA5A5_0001);
        check("land_loc", 32'(dp.location_out), 32'd17);
        check("land_rot", 32'(dp.rotation_out), 32'd2);
        cycle();
        check("touch_clear", 32'(state), 32'd3);
        check("clear_board_hold", dp.board_out, 32'hA5A5_0001);
        cycle();
        check("touch_newboard", 32'(state), 32'd4);
        check("newboard_board", dp.board_out, 32'h1234_5678);
        cycle();
        check("touch_gen", 32'(state), 32'd0);
        check("gen_loc", 32'(dp.location_out), 32'd0);
        check("gen_rot", 32'(dp.rotation_out), 32'd0);
        cycle();
        m0 = nc;
        check("touch_move", 32'(state), 32'd1);
        check("touch_pieces", 32'(piece_count), 32'd2);

        // Redraw overflow leads to GAMEOVER, rotate edge restarts the board
        dp.touched  = 1'b1;
        dp.board_in = 32'hDEAD_BEEF;
        cycle();
        dp.touched = 1'b0;
        cycle();
        dp.error_in = 1'b1;
        cycle();
        dp.error_in = 1'b0;
        check("err_gameover", 32'(state), 32'd5);
        check("err_game_over", 32'(game_over), 32'd1);
        check("err_board", dp.board_out, 32'hDEAD_BEEF);
        cycle();
        check("err_hold", 32'(state), 32'd5);
        check("err_old", 32'(old_state), 32'd5);
        btn_rotate = 1'b1;
        cycle();
        release_btns();
        check("go_newboard", 32'(state), 32'd4);
        check("go_board_zero", dp.board_out, 32'd0);
        check("go_game_over", 32'(game_over), 32'd0);
        cycle();
        cycle();
        m0 = nc;
        check("go_move", 32'(state), 32'd1);

        // Piece count saturation: every MOVE ends at once
        dp.touched = 1'b1;
        repeat (1400) cycle();
        dp.touched = 1'b0;
        m0 = nc;
        check("sat_move", 32'(state), 32'd1);
        check("sat_pieces", 32'(piece_count), 32'd255);

        // Reset with a move pending: nothing issued afterwards
        press(1, 0, 0, 2'd1, 0);
        cycle();
        release_btns();
        restart = 1'b0;
        cycle();
        check_reset_vals();
        restart = 1'b1;
        cycle();
        check("post_rst_gen", 32'(state), 32'd0);
        repeat (12) cycle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
